// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op encodings, FSM states and control-word type for the ALU sequencer
package alu_seq_pkg;

   localparam int ALU_W = 13;
   localparam int OP_W  = 4;
   localparam int REG_W = 4;

   // Values double as the bit position in the one-hot ALU control word.
   typedef enum logic [OP_W-1:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_MUL  = 4'd4,
      OP_DIV  = 4'd5,
      OP_SHR  = 4'd6,
      OP_SHRA = 4'd7,
      OP_SHL  = 4'd8,
      OP_ROR  = 4'd9,
      OP_ROL  = 4'd10,
      OP_NEG  = 4'd11,
      OP_NOT  = 4'd12
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_Y,
      S_EXEC,
      S_WB_LO,
      S_WB_HI,
      S_DONE,
      S_ERR
   } state_t;

   typedef struct packed {
      logic [REG_W-1:0] reg_sel;
      logic             r_out;
      logic             r_in;
      logic             y_in;
      logic [ALU_W-1:0] alu_ctrl;
      logic             z_in;
      logic             zlo_out;
      logic             zhi_out;
      logic             lo_in;
      logic             hi_in;
      logic             busy;
      logic             done;
      logic             err;
   } ctrl_t;

   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_unary(input logic [OP_W-1:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic is_legal(input logic [OP_W-1:0] op);
      return op <= OP_NOT;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction request and datapath strobe bundle around the ALU sequencer
interface alu_sequencer_if;
   import alu_seq_pkg::*;

   logic             start;
   logic [OP_W-1:0]  op;
   logic [REG_W-1:0] ra;
   logic [REG_W-1:0] rb;
   logic [REG_W-1:0] rc;

   logic [REG_W-1:0] reg_sel;
   logic             r_out;
   logic             r_in;
   logic             y_in;
   logic [ALU_W-1:0] alu_ctrl;
   logic             z_in;
   logic             zlo_out;
   logic             zhi_out;
   logic             lo_in;
   logic             hi_in;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, op, ra, rb, rc,
      input  reg_sel, r_out, r_in, y_in, alu_ctrl, z_in, zlo_out, zhi_out,
             lo_in, hi_in, busy, done, err
   );

   modport slave (
      input  start, op, ra, rb, rc,
      output reg_sel, r_out, r_in, y_in, alu_ctrl, z_in, zlo_out, zhi_out,
             lo_in, hi_in, busy, done, err
   );

endinterface

// File: rtl/exec_wait_counter.sv
// rtl/exec_wait_counter.sv - loadable down-counter timing multi-cycle EXEC
module exec_wait_counter #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         clear_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         last,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign last = (count == W'(1));
   assign zero = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control FSM walking one ALU instruction through load, execute and write-back
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 1
) (
   input  logic           clock,
   input  logic           clear_n,
   alu_sequencer_if.slave bus
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [ALU_W-1:0] ALU_ONE = ALU_W'(1);

   state_t           state;
   state_t           state_n;
   logic [OP_W-1:0]  op_q;
   logic [REG_W-1:0] ra_q;
   logic [REG_W-1:0] rb_q;
   logic [REG_W-1:0] rc_q;
   ctrl_t            ctrl_q;
   ctrl_t            ctrl_n;

   logic             accept;
   logic [OP_W-1:0]  f_op;
   logic [REG_W-1:0] f_ra;
   logic [REG_W-1:0] f_rb;
   logic [REG_W-1:0] f_rc;
   logic [CNT_W-1:0] load_val;
   logic             cnt_dec;
   logic             cnt_last;
   logic             cnt_zero;
   logic             z_last_n;

   // Strobes for a given state; evaluated on the next state so outputs leave a register.
   function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] op,
                                    input logic [REG_W-1:0] ra, input logic [REG_W-1:0] rb,
                                    input logic [REG_W-1:0] rc, input logic z_last);
      ctrl_t c;
      c = '0;
      case (s)
         S_LOAD_Y: begin
            c.reg_sel = rb;
            c.r_out   = 1'b1;
            c.y_in    = 1'b1;
            c.busy    = 1'b1;
         end
         S_EXEC: begin
            c.alu_ctrl = ALU_ONE << op;
            c.z_in     = z_last;
            c.busy     = 1'b1;
            if (!is_unary(op)) begin
               c.reg_sel = rc;
               c.r_out   = 1'b1;
            end
         end
         S_WB_LO: begin
            c.zlo_out = 1'b1;
            c.busy    = 1'b1;
            if (is_muldiv(op)) begin
               c.lo_in = 1'b1;
            end else begin
               c.reg_sel = ra;
               c.r_in    = 1'b1;
            end
         end
         S_WB_HI: begin
            c.zhi_out = 1'b1;
            c.hi_in   = 1'b1;
            c.busy    = 1'b1;
         end
         S_DONE: begin
            c.done = 1'b1;
            c.busy = 1'b1;
         end
         S_ERR: begin
            c.err = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (is_legal(bus.op)) begin
                  state_n = S_LOAD_Y;
                  accept  = 1'b1;
               end else begin
                  state_n = S_ERR;
               end
            end
         end
         S_LOAD_Y: state_n = S_EXEC;
         S_EXEC:   if (cnt_zero) state_n = S_WB_LO;
         S_WB_LO:  state_n = is_muldiv(op_q) ? S_WB_HI : S_DONE;
         S_WB_HI:  state_n = S_DONE;
         S_DONE:   state_n = S_IDLE;
         S_ERR:    state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // On acceptance the latches are not yet loaded, so LOAD_Y decodes from the live request.
   always_comb begin
      f_op = accept ? bus.op : op_q;
      f_ra = accept ? bus.ra : ra_q;
      f_rb = accept ? bus.rb : rb_q;
      f_rc = accept ? bus.rc : rc_q;
   end

   always_comb begin
      if (bus.op == OP_MUL) begin
         load_val = CNT_W'(MUL_CYCLES);
      end else if (bus.op == OP_DIV) begin
         load_val = CNT_W'(DIV_CYCLES);
      end else begin
         load_val = CNT_W'(1);
      end
   end

   // Counter holds N in LOAD_Y, then the EXEC cycles still to come after the current one.
   assign cnt_dec  = (state == S_LOAD_Y) || ((state == S_EXEC) && !cnt_zero);
   assign z_last_n = (state_n == S_EXEC) && cnt_last;
   assign ctrl_n   = decode(state_n, f_op, f_ra, f_rb, f_rc, z_last_n);

   exec_wait_counter #(
      .W (CNT_W)
   ) u_wait (
      .clock    (clock),
      .clear_n  (clear_n),
      .load     (accept),
      .load_val (load_val),
      .dec      (cnt_dec),
      .last     (cnt_last),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state  <= S_IDLE;
         op_q   <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
         ctrl_q <= '0;
      end else begin
         state  <= state_n;
         ctrl_q <= ctrl_n;
         if (accept) begin
            op_q <= bus.op;
            ra_q <= bus.ra;
            rb_q <= bus.rb;
            rc_q <= bus.rc;
         end
      end
   end

   assign bus.reg_sel  = ctrl_q.reg_sel;
   assign bus.r_out    = ctrl_q.r_out;
   assign bus.r_in     = ctrl_q.r_in;
   assign bus.y_in     = ctrl_q.y_in;
   assign bus.alu_ctrl = ctrl_q.alu_ctrl;
   assign bus.z_in     = ctrl_q.z_in;
   assign bus.zlo_out  = ctrl_q.zlo_out;
   assign bus.zhi_out  = ctrl_q.zhi_out;
   assign bus.lo_in    = ctrl_q.lo_in;
   assign bus.hi_in    = ctrl_q.hi_in;
   assign bus.busy     = ctrl_q.busy;
   assign bus.done     = ctrl_q.done;
   assign bus.err      = ctrl_q.err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer against a per-cycle strobe trace model
module tb_alu_sequencer;

   localparam int MUL_N = 3;
   localparam int DIV_N = 2;

   logic clock;
   logic clear_n;
   int   vectors     = 0;
   int   miscompares = 0;

   alu_sequencer_if bus ();

   alu_sequencer #(
      .MUL_CYCLES (MUL_N),
      .DIV_CYCLES (DIV_N)
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // {reg_sel, r_out, r_in, y_in, alu_ctrl, z_in, zlo_out, zhi_out, lo_in, hi_in, busy, done, err}
   function automatic logic [27:0] vec(input logic [3:0] sel, input logic r_out, input logic r_in,
                                       input logic y_in, input logic [12:0] alu, input logic z_in,
                                       input logic zlo, input logic zhi, input logic lo,
                                       input logic hi, input logic busy, input logic done,
                                       input logic err);
      return {sel, r_out, r_in, y_in, alu, z_in, zlo, zhi, lo, hi, busy, done, err};
   endfunction

   function automatic logic [27:0] obs();
      return {bus.reg_sel, bus.r_out, bus.r_in, bus.y_in, bus.alu_ctrl, bus.z_in, bus.zlo_out,
              bus.zhi_out, bus.lo_in, bus.hi_in, bus.busy, bus.done, bus.err};
   endfunction

   task automatic check(input string tag, input logic [27:0] exp);
      logic [27:0] got;
      got = obs();
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Expected strobes for every cycle after the accepting edge, ending with one idle cycle.
   task automatic build_trace(input int op, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [3:0] rc, output logic [27:0] q[$]);
      int          n;
      bit          unary;
      bit          md;
      logic [12:0] alu;
      int          onehot;
      q = {};
      if (op > 12) begin
         q.push_back(vec(4'd0, 0, 0, 0, 13'd0, 0, 0, 0, 0, 0, 0, 0, 1));
         q.push_back('0);
         return;
      end
      md     = (op == 4) || (op == 5);
      unary  = (op == 11) || (op == 12);
      n      = (op == 4) ? MUL_N : (op == 5) ? DIV_N : 1;
      onehot = 1 << op;
      alu    = onehot[12:0];
      q.push_back(vec(rb, 1, 0, 1, 13'd0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < n; i++) begin
         q.push_back(vec(unary ? 4'd0 : rc, !unary, 0, 0, alu, i == n - 1, 0, 0, 0, 0, 1, 0, 0));
      end
      if (md) begin
         q.push_back(vec(4'd0, 0, 0, 0, 13'd0, 0, 1, 0, 1, 0, 1, 0, 0));
         q.push_back(vec(4'd0, 0, 0, 0, 13'd0, 0, 0, 1, 0, 1, 1, 0, 0));
      end else begin
         q.push_back(vec(ra, 0, 1, 0, 13'd0, 0, 1, 0, 0, 0, 1, 0, 0));
      end
      q.push_back(vec(4'd0, 0, 0, 0, 13'd0, 0, 0, 0, 0, 0, 1, 1, 0));
      q.push_back('0);
   endtask

   // Entered and left in an idle cycle, #1 after a rising edge.
   task automatic run_instr(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input bit noise, input int abort_at,
                            input string tag);
      logic [27:0] exp_q[$];
      build_trace(int'(op), ra, rb, rc, exp_q);
      bus.start = 1'b1;
      bus.op    = op;
      bus.ra    = ra;
      bus.rb    = rb;
      bus.rc    = rc;
      @(posedge clock);
      #1;
      for (int k = 0; k < exp_q.size(); k++) begin
         check($sformatf("%s[%0d]", tag, k), exp_q[k]);
         if (k == abort_at) begin
            #1 clear_n = 1'b0;
            #1 check($sformatf("%s_async_clear", tag), '0);
            @(posedge clock);
            #1 check($sformatf("%s_held_clear", tag), '0);
            clear_n   = 1'b1;
            bus.start = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(posedge clock);
               #1 check($sformatf("%s_post_clear[%0d]", tag, j), '0);
            end
            return;
         end
         bus.start = noise && (k != exp_q.size() - 1);
         bus.op    = 4'($urandom);
         bus.ra    = 4'($urandom);
         bus.rb    = 4'($urandom);
         bus.rc    = 4'($urandom);
         if (k != exp_q.size() - 1) begin
            @(posedge clock);
            #1;
         end
      end
      bus.start = 1'b0;
   endtask

   initial begin
      clear_n   = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.ra    = '0;
      bus.rb    = '0;
      bus.rc    = '0;
      #3 check("reset_async", '0);
      bus.start = 1'b1;
      @(posedge clock);
      #1 check("reset_held", '0);
      bus.start = 1'b0;
      clear_n   = 1'b1;
      @(posedge clock);
      #1 check("idle_after_reset", '0);

      run_instr(4'd2,  4'd3, 4'd1, 4'd2, 1'b0, -1, "add");
      run_instr(4'd4,  4'd7, 4'd8, 4'd9, 1'b0, -1, "mul");
      run_instr(4'd12, 4'd6, 4'd5, 4'd4, 1'b0, -1, "not");
      run_instr(4'd11, 4'd2, 4'd9, 4'd1, 1'b0, -1, "neg");
      run_instr(4'd14, 4'd1, 4'd2, 4'd3, 1'b0, -1, "err14");
      run_instr(4'd13, 4'd1, 4'd2, 4'd3, 1'b1, -1, "err13");
      run_instr(4'd2,  4'd3, 4'd1, 4'd2, 1'b1, -1, "add_start_ignored");
      run_instr(4'd5,  4'd1, 4'd2, 4'd3, 1'b0,  4, "div_clear_wbhi");
      run_instr(4'd3,  4'd4, 4'd5, 4'd6, 1'b0, -1, "sub_after_clear");

      for (int i = 0; i < 40; i++) begin
         run_instr(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
